// File: rtl/mem_port_arbiter_pkg.sv
// loopyV_data_types: arbiter state, owner and captured-request types for mem_port_arbiter.
package loopyV_data_types;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} arbStateType;
    typedef enum logic [1:0] {NONE, IF, DATA} arbOwnerType;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } arbReqType;

    localparam logic [3:0] FULL_MASK = 4'hF;

    function automatic arbReqType readReq(input logic [31:0] addr);
        return '{we: 1'b0, addr: addr, wdata: 32'h0, mask: FULL_MASK};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_guard.sv
// mem_arb_starve_guard: counts consecutive data wins while fetch waits; forces fetch at the limit.
module mem_arb_starve_guard #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic arstn,
    input  logic arbitrate,
    input  logic ifReq,
    input  logic fetchWin,
    output logic forceFetch
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] count;

    assign forceFetch = count == CW'(STARVE_LIMIT);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) count <= '0;
        else if (arbitrate) count <= (fetchWin || !ifReq) ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, data first.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT consecutive data wins.
module mem_port_arbiter
    import loopyV_data_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        ifReq,
    input  logic [31:0] ifAddr,
    output logic        ifGnt,
    output logic        ifRValid,
    output logic [31:0] ifRData,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWData,
    input  logic [3:0]  dMask,
    output logic        dGnt,
    output logic        dRValid,
    output logic [31:0] dRData,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic [3:0]  memMask,
    input  logic        memGnt,
    input  logic        memRValid,
    input  logic [31:0] memRData,
    output logic        busy
);
    arbStateType state;
    arbOwnerType owner;
    arbReqType   req;
    arbReqType   nextReq;
    logic [31:0] ifRDataQ;
    logic [31:0] dRDataQ;
    logic        forceFetch;
    logic        takeData;
    logic        takeIf;

`ifdef ARB_STARVE_GUARD_EN
    mem_arb_starve_guard #(.STARVE_LIMIT(STARVE_LIMIT)) uGuard (
        .clk        (clk),
        .arstn      (arstn),
        .arbitrate  (state == IDLE && (dReq || ifReq)),
        .ifReq      (ifReq),
        .fetchWin   (takeIf),
        .forceFetch (forceFetch)
    );
`else
    logic unusedLimit;
    assign unusedLimit = ^STARVE_LIMIT;
    assign forceFetch  = 1'b0;
`endif

    assign takeData = dReq && !(forceFetch && ifReq);
    assign takeIf   = ifReq && !takeData;

    always_comb begin
        nextReq = readReq(takeData ? dAddr : ifAddr);
        if (takeData && dWe) nextReq = '{we: 1'b1, addr: dAddr, wdata: dWData, mask: dMask};
    end

    // Memory-side outputs come straight from the captured request register.
    assign memWe    = req.we;
    assign memAddr  = req.addr;
    assign memWData = req.wdata;
    assign memMask  = req.mask;
    assign busy     = state != IDLE;

    assign ifGnt    = state == ISSUE && owner == IF && memGnt;
    assign dGnt     = state == ISSUE && owner == DATA && memGnt;
    assign ifRValid = state == WAIT_RESP && owner == IF && memRValid;
    assign dRValid  = state == WAIT_RESP && owner == DATA && memRValid;
    assign ifRData  = ifRValid ? memRData : ifRDataQ;
    assign dRData   = dRValid ? memRData : dRDataQ;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state    <= IDLE;
            owner    <= NONE;
            req      <= '0;
            memReq   <= 1'b0;
            ifRDataQ <= '0;
            dRDataQ  <= '0;
        end else begin
            ifRDataQ <= ifRData;
            dRDataQ  <= dRData;
            case (state)
                IDLE: begin
                    if (takeData || takeIf) begin
                        state  <= ISSUE;
                        owner  <= takeData ? DATA : IF;
                        req    <= nextReq;
                        memReq <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (memGnt) begin
                        memReq <= 1'b0;
                        state  <= req.we ? IDLE : WAIT_RESP;
                        if (req.we) owner <= NONE;
                    end
                end
                WAIT_RESP: begin
                    if (memRValid) begin
                        state <= IDLE;
                        owner <= NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= NONE;
                end
            endcase
        end
    end

endmodule
